// File: rtl/phase_seq.sv
// rtl/phase_seq.sv - five-phase instruction sequencer with optional perf counters (PHASE_SEQ_PERF_CNT_EN)
module phase_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [5:0]  op,
    input  logic [5:0]  irfunc,
    input  logic [4:0]  regimm,
    input  logic        mem_ready,
    input  logic        error,
    output logic [4:0]  p,
    output logic        instr_done,
    output logic        illegal,
    output logic        excp,
    output logic        exc_seen,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ins_cnt
);

    // state encoding doubles as the one-hot phase vector, so p comes straight from the register
    typedef enum logic [4:0] {
        S_IDLE = 5'b00000,
        S_P0   = 5'b00001,
        S_P1   = 5'b00010,
        S_P2   = 5'b00100,
        S_P3   = 5'b01000,
        S_P4   = 5'b10000
    } state_t;

    state_t state, state_nx;
    logic   legal, is_branch, is_lw, is_sw, is_addsub;

    always_comb begin
        legal     = 1'b0;
        is_branch = 1'b0;
        case (op)
            6'b000000: begin
                case (irfunc)
                    6'b100000, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
                    6'b100111, 6'b101010, 6'b101011, 6'b001000, 6'b001001: legal = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
            6'b001001, 6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110,
            6'b100011, 6'b101011, 6'b000010, 6'b000011: legal = 1'b1;
            6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
                legal     = 1'b1;
                is_branch = 1'b1;
            end
            6'b000001: begin
                if (regimm == 5'b00000 || regimm == 5'b00001) begin
                    legal     = 1'b1;
                    is_branch = 1'b1;
                end
            end
            default: legal = 1'b0;
        endcase
    end

    assign is_lw     = (op == 6'b100011);
    assign is_sw     = (op == 6'b101011);
    assign is_addsub = (op == 6'b000000) && (irfunc == 6'b100000 || irfunc == 6'b100010);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        instr_done = 1'b0;
        illegal    = 1'b0;
        excp       = 1'b0;
        case (state)
            S_IDLE: if (run) state_nx = S_P0;
            S_P0:   if (mem_ready) state_nx = S_P1;
            S_P1: begin
                if (legal) begin
                    state_nx = S_P2;
                end else begin
                    illegal  = 1'b1;
                    state_nx = run ? S_P0 : S_IDLE;
                end
            end
            S_P2: begin
                if (is_branch) begin
                    instr_done = 1'b1;
                    state_nx   = run ? S_P0 : S_IDLE;
                end else begin
                    state_nx = S_P3;
                end
            end
            S_P3: begin
                if (is_sw) begin
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_nx   = run ? S_P0 : S_IDLE;
                    end
                end else if (is_lw) begin
                    if (mem_ready) state_nx = S_P4;
                end else begin
                    state_nx = S_P4;
                end
            end
            S_P4: begin
                excp       = is_addsub && error;
                instr_done = 1'b1;
                state_nx   = run ? S_P0 : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign p = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    exc_seen <= 1'b0;
        else if (excp) exc_seen <= 1'b1;
    end

`ifdef PHASE_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt <= 32'd0;
            ins_cnt <= 32'd0;
        end else begin
            if (state != S_IDLE) cyc_cnt <= cyc_cnt + 32'd1;
            if (instr_done)      ins_cnt <= ins_cnt + 32'd1;
        end
    end
`else
    assign cyc_cnt = 32'd0;
    assign ins_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_phase_seq.sv
// tb/tb_phase_seq.sv - table-driven bench for phase_seq plus multi-cycle corner sequences
module tb_phase_seq;

    logic        clk = 1'b0;
    logic        reset, run, mem_ready, error;
    logic [5:0]  op, irfunc;
    logic [4:0]  regimm;
    logic [4:0]  p;
    logic        instr_done, illegal, excp, exc_seen;
    logic [31:0] cyc_cnt, ins_cnt;

    int total = 0;
    int bad   = 0;

`ifdef PHASE_SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    phase_seq dut (
        .clk(clk), .reset(reset), .run(run), .op(op), .irfunc(irfunc), .regimm(regimm),
        .mem_ready(mem_ready), .error(error), .p(p), .instr_done(instr_done),
        .illegal(illegal), .excp(excp), .exc_seen(exc_seen), .cyc_cnt(cyc_cnt), .ins_cnt(ins_cnt)
    );

    always #5 clk = ~clk;

    // w0/w3: memory wait cycles in P0/P3; mr3lo drives mem_ready low in the first P3 cycle
    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rim;
        logic       err;
        int         w0;
        int         w3;
        bit         mr3lo;
        int         drop;
        int         lat;
        bit         ill;
        bit         exc;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // starts with the DUT in P0 just after an edge; returns at the negedge of the final cycle
    task automatic run_instr(input vec_t v, output int lat, output bit ok_seq,
                             output bit done_seen, output bit ill_seen, output bit exc_last);
        logic [4:0] ep;
        op = v.op; irfunc = v.fn; regimm = v.rim; error = v.err;
        lat = 0; ok_seq = 1'b1; done_seen = 1'b0; ill_seen = 1'b0; exc_last = 1'b0;
        for (int c = 0; c < 60; c++) begin
            mem_ready = !((c < v.w0) || (c >= v.w0 + 3 && c < v.w0 + 3 + v.w3) ||
                          (v.mr3lo && c == v.w0 + 3));
            run = (c >= v.drop) ? 1'b0 : 1'b1;
            if (c <= v.w0)                ep = 5'b00001;
            else if (c == v.w0 + 1)       ep = 5'b00010;
            else if (c == v.w0 + 2)       ep = 5'b00100;
            else if (c <= v.w0 + 3 + v.w3) ep = 5'b01000;
            else                          ep = 5'b10000;
            @(negedge clk);
            if (p !== ep) ok_seq = 1'b0;
            lat = c + 1;
            if (illegal)    ill_seen = 1'b1;
            if (instr_done) done_seen = 1'b1;
            exc_last = excp;
            if (instr_done || illegal) break;
            if (excp) ok_seq = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        run = 1'b1; mem_ready = 1'b1; error = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    int         lat, exp_cyc, exp_ins;
    bit         ok, dn, il, ex, sticky;
    vec_t       hv;

    initial begin
        tbl[0]  = '{6'b000000, 6'b100000, 5'd0, 1'b0, 0, 0, 1'b0, 99, 5,  1'b0, 1'b0}; // add
        tbl[1]  = '{6'b000000, 6'b100010, 5'd0, 1'b1, 0, 0, 1'b0, 99, 5,  1'b0, 1'b1}; // sub overflow
        tbl[2]  = '{6'b000100, 6'b000000, 5'd0, 1'b0, 0, 0, 1'b0, 99, 3,  1'b0, 1'b0}; // beq
        tbl[3]  = '{6'b101011, 6'b000000, 5'd0, 1'b0, 0, 0, 1'b0, 99, 4,  1'b0, 1'b0}; // sw
        tbl[4]  = '{6'b100011, 6'b000000, 5'd0, 1'b0, 2, 3, 1'b0, 99, 10, 1'b0, 1'b0}; // lw with waits
        tbl[5]  = '{6'b111111, 6'b000000, 5'd0, 1'b0, 0, 0, 1'b0, 99, 2,  1'b1, 1'b0}; // bad opcode
        tbl[6]  = '{6'b000000, 6'b000000, 5'd0, 1'b0, 0, 0, 1'b0, 99, 2,  1'b1, 1'b0}; // bad funct
        tbl[7]  = '{6'b000001, 6'b000000, 5'd0, 1'b0, 0, 0, 1'b0, 99, 3,  1'b0, 1'b0}; // bltz
        tbl[8]  = '{6'b000001, 6'b000000, 5'd1, 1'b0, 0, 0, 1'b0, 99, 3,  1'b0, 1'b0}; // bgez
        tbl[9]  = '{6'b000001, 6'b000000, 5'd2, 1'b0, 0, 0, 1'b0, 99, 2,  1'b1, 1'b0}; // bad regimm
        tbl[10] = '{6'b000010, 6'b000000, 5'd0, 1'b0, 0, 0, 1'b0, 99, 5,  1'b0, 1'b0}; // j
        tbl[11] = '{6'b000000, 6'b001000, 5'd0, 1'b0, 0, 0, 1'b0, 99, 5,  1'b0, 1'b0}; // jr
        tbl[12] = '{6'b101011, 6'b000000, 5'd0, 1'b0, 1, 2, 1'b0, 99, 7,  1'b0, 1'b0}; // sw with waits
        tbl[13] = '{6'b000000, 6'b100001, 5'd0, 1'b1, 0, 0, 1'b0, 99, 2,  1'b1, 1'b0}; // addu not legal
        tbl[14] = '{6'b001101, 6'b000000, 5'd0, 1'b1, 0, 0, 1'b0, 99, 5,  1'b0, 1'b0}; // ori, error ignored
        tbl[15] = '{6'b000000, 6'b100000, 5'd0, 1'b1, 0, 0, 1'b1, 99, 5,  1'b0, 1'b1}; // add, P3 ignores mem_ready

        op = 6'd0; irfunc = 6'd0; regimm = 5'd0;
        reset = 1'b0; run = 1'b1; mem_ready = 1'b1; error = 1'b0;
        @(negedge clk);
        check("rst_p", p, 5'b00000);
        check("rst_done", instr_done, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_excp", excp, 1'b0);
        check("rst_exc_seen", exc_seen, 1'b0);
        check("rst_cyc", cyc_cnt, 32'd0);
        check("rst_ins", ins_cnt, 32'd0);

        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("first_p0", p, 5'b00001);

        exp_cyc = 0; exp_ins = 0; sticky = 1'b0;
        for (int i = 0; i < 16; i++) begin
            run_instr(tbl[i], lat, ok, dn, il, ex);
            check($sformatf("v%0d_lat", i), lat, tbl[i].lat);
            check($sformatf("v%0d_pseq", i), ok, 1'b1);
            check($sformatf("v%0d_done", i), dn, !tbl[i].ill);
            check($sformatf("v%0d_illegal", i), il, tbl[i].ill);
            check($sformatf("v%0d_excp", i), ex, tbl[i].exc);
            exp_cyc += tbl[i].lat;
            if (!tbl[i].ill) exp_ins++;
            if (tbl[i].exc) sticky = 1'b1;
            @(posedge clk); #1;
            check($sformatf("v%0d_next_p0", i), p, 5'b00001);
            check($sformatf("v%0d_exc_seen", i), exc_seen, sticky);
        end
        check("tbl_cyc", cyc_cnt, PERF ? exp_cyc : 0);
        check("tbl_ins", ins_cnt, PERF ? exp_ins : 0);

        // beq then sw; run dropped mid-sw is ignored until the sw retires
        apply_reset();
        check("seqa_p0", p, 5'b00001);
        run_instr(tbl[2], lat, ok, dn, il, ex);
        check("seqa_beq_lat", lat, 3);
        @(posedge clk); #1;
        hv = tbl[3];
        hv.drop = 0;
        run_instr(hv, lat, ok, dn, il, ex);
        check("seqa_sw_lat", lat, 4);
        check("seqa_sw_pseq", ok, 1'b1);
        @(posedge clk); #1;
        check("seqa_idle", p, 5'b00000);
        check("seqa_ins", ins_cnt, PERF ? 2 : 0);
        check("seqa_cyc", cyc_cnt, PERF ? 7 : 0);
        check("seqa_exc_clear", exc_seen, 1'b0);
        @(posedge clk); #1;
        check("seqa_idle_hold", p, 5'b00000);

        // sub overflow with run dropped in P3
        run = 1'b1;
        @(posedge clk); #1;
        hv = tbl[1];
        hv.drop = 3;
        run_instr(hv, lat, ok, dn, il, ex);
        check("seqb_lat", lat, 5);
        check("seqb_excp", ex, 1'b1);
        check("seqb_done", dn, 1'b1);
        check("seqb_exc_seen_pre", exc_seen, 1'b0);
        @(posedge clk); #1;
        check("seqb_idle", p, 5'b00000);
        check("seqb_exc_seen", exc_seen, 1'b1);

        // reset during a P3 wait of lw
        run = 1'b1; op = 6'b100011; irfunc = 6'd0; mem_ready = 1'b1; error = 1'b0;
        @(posedge clk); #1;
        check("seqc_p0", p, 5'b00001);
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("seqc_hold_p3", p, 5'b01000);
        check("seqc_no_done", instr_done, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("seqc_rst_p", p, 5'b00000);
        check("seqc_rst_done", instr_done, 1'b0);
        check("seqc_rst_cyc", cyc_cnt, 32'd0);
        check("seqc_rst_ins", ins_cnt, 32'd0);
        check("seqc_rst_exc", exc_seen, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_seq.md
PHASE_SEQ -- requirements
Module: phase_seq

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL: run  input  1  level; 1 = fetch and execute instructions, 0 = park in IDLE at the next instruction boundary.
REQ-004 SHALL: op  input  6  IR[31:26]; stable from P1 through the end of the instruction.
REQ-005 SHALL: irfunc  input  6  IR[5:0]; same stability as op.
REQ-006 SHALL: regimm  input  5  IR[20:16]; selects bltz (00000) or bgez (00001) when op=000001.
REQ-007 SHALL: mem_ready  input  1  memory handshake; 1 = the current fetch or data access completes this cycle.
REQ-008 SHALL: error  input  1  ALU overflow flag; valid during P4.
REQ-009 SHALL: p  output  5  one-hot phase vector (p[0]=P0 ... p[4]=P4); 00000 in IDLE.
REQ-010 SHALL: instr_done  output  1  one-cycle pulse in the last phase of every retired instruction.
REQ-011 SHALL: illegal  output  1  one-cycle pulse in P1 when the opcode does not decode.
REQ-012 SHALL: excp  output  1  asserted in P4 when (add or sub) and error=1.
REQ-013 SHALL: exc_seen  output  1  sticky flag, set when excp=1; cleared only by reset.
REQ-014 SHALL: cyc_cnt  output  32  count of non-IDLE cycles (see Configuration).
REQ-015 SHALL: ins_cnt  output  32  count of instr_done pulses (see Configuration).

Function
REQ-016 SHALL: FSM states are IDLE, P0, P1, P2, P3 and P4; p is a registered one-hot encoding of P0..P4 and is never multi-hot.
REQ-017 SHALL: IDLE -> P0 when run=1; otherwise IDLE holds.
REQ-018 SHALL: P0 (fetch) -> P1 when mem_ready=1; otherwise P0 holds for any number of wait cycles.
REQ-019 SHALL: P1 (decode) -> P2 when the instruction is legal; when it is illegal, illegal pulses and the FSM goes to P0 (or to IDLE if run=0), with no instr_done.
REQ-020 SHALL: the legal set is:
- R-type (op=000000), funct 100000, 100010, 100011, 100100, 100101, 100110, 100111, 101010, 101011, 001000, 001001;
- op 001001, 001010, 001011, 001100, 001101, 001110, 100011, 101011, 000010, 000011, 000100, 000101, 000110, 000111;
- op 000001 with regimm 00000 or 00001.
REQ-021 SHALL: P2 -> end of instruction for branches (beq, bne, blez, bgtz, bltz, bgez), with instr_done asserted in P2; every other instruction goes P2 -> P3.
REQ-022 SHALL: in P3, lw and sw hold while mem_ready=0; sw then ends (instr_done in P3) and lw goes to P4; all other instructions go P3 -> P4 regardless of mem_ready.
REQ-023 SHALL: P4 always ends the instruction with instr_done asserted.
REQ-024 SHALL: at end of instruction, the next state is P0 if run=1 and IDLE if run=0; run is ignored mid-instruction.
REQ-025 SHALL: excp=1 still retires the instruction (instr_done=1); excp is combinational from state, op, irfunc and error.
REQ-026 SHALL: instruction latency in cycles, with no memory wait, is: branch 3, sw 4, all others 5.

Reset
REQ-027 SHALL: while reset=0, state is IDLE, p=00000, instr_done=illegal=excp=0, exc_seen=0, cyc_cnt=ins_cnt=0, asynchronously.
REQ-028 SHALL: reset asserted mid-instruction (including during a memory wait) aborts the instruction immediately, with no instr_done.
REQ-029 SHALL: the first P0 follows reset release by exactly one clock edge with run=1.

Configuration
REQ-030 SHALL: macro PHASE_SEQ_PERF_CNT_EN, when defined, enables both counters:
- cyc_cnt increments on every cycle not in IDLE;
- ins_cnt increments on every instr_done;
- both wrap from FFFFFFFF to 0.
REQ-031 SHALL: when PHASE_SEQ_PERF_CNT_EN is undefined, the counter registers are absent and cyc_cnt=ins_cnt=0 constantly; the ports remain.

Verification
REQ-032 SHALL: reset release, run=1, mem_ready=1, add (op=000000, funct=100000), error=0 -> p sequence 00001, 00010, 00100, 01000, 10000, with instr_done in the 5th cycle, then 00001.
REQ-033 SHALL: beq then sw, mem_ready=1 -> beq retires in 3 cycles and sw in 4; ins_cnt=2 and cyc_cnt=7 (with PERF_CNT_EN defined).
REQ-034 SHALL: lw with mem_ready=0 for 2 cycles in P0 and 3 cycles in P3 -> retires after 10 cycles, with p held stable during each wait.
REQ-035 SHALL: op=111111 -> illegal pulses in P1, next state is P0, no instr_done, and ins_cnt is unchanged.
REQ-036 SHALL: sub with error=1 in P4 -> excp=1 in P4, exc_seen=1 from the next cycle, and instr_done=1; run dropped during P3 -> next state is IDLE, p=00000.
REQ-037 SHALL: reset=0 asserted in P3 of lw during a wait -> p=00000 immediately, no instr_done, and counters are 0.
